// File: rtl/mem_capture_mon_pkg.sv
// mem_cap_pkg: shared types and helpers for the frame capture monitor.
//   mem_cap_state_e : capture/readout controller states
//   adc_word_t      : one ADC way-bus word at the default geometry
//   addr_wrap()     : circular address arithmetic over the whole buffer
//   clamp_max()     : saturate a value to an upper bound
package mem_cap_pkg;

    localparam int DEF_WAY_WIDTH = 16;
    localparam int DEF_ADC_WIDTH = 8;

    typedef logic [DEF_WAY_WIDTH-1:0][DEF_ADC_WIDTH-1:0] adc_word_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_ARMED,
        ST_POST,
        ST_LOAD,
        ST_READ
    } mem_cap_state_e;

    // base +/- off modulo depth; works for any depth, reduces to a
    // truncation when depth is a power of two.
    function automatic int unsigned addr_wrap(input int unsigned base,
                                              input int unsigned off,
                                              input bit          sub,
                                              input int unsigned depth);
        if (sub)
            return (base + depth - (off % depth)) % depth;
        return (base + off) % depth;
    endfunction

    function automatic int unsigned clamp_max(input int unsigned v,
                                              input int unsigned max_v);
        return (v > max_v) ? max_v : v;
    endfunction

endpackage

// File: rtl/mem_capture_mon_if.sv
// mem_capture_mon_if: ADC capture side and serial monitor side of the
// frame capture monitor.
//   capture : data_in, data_valid, arm, mode, pre_len, trig, abort
//   monitor : data_mon, mon_valid, mon_ready, mon_last
//   status  : busy, done, trig_early
// master = stimulus/consumer side, slave = the monitor itself.
interface mem_capture_mon_if #(
    parameter int WAY_WIDTH = 16,
    parameter int ADC_WIDTH = 8,
    parameter int PRE_W     = 5
) ();

    logic [WAY_WIDTH-1:0][ADC_WIDTH-1:0] data_in;
    logic                                data_valid;
    logic                                arm;
    logic                                mode;
    logic [PRE_W-1:0]                    pre_len;
    logic                                trig;
    logic                                abort;
    logic                                data_mon;
    logic                                mon_valid;
    logic                                mon_ready;
    logic                                mon_last;
    logic                                busy;
    logic                                done;
    logic                                trig_early;

    modport master (
        output data_in, data_valid, arm, mode, pre_len, trig, abort, mon_ready,
        input  data_mon, mon_valid, mon_last, busy, done, trig_early
    );

    modport slave (
        input  data_in, data_valid, arm, mode, pre_len, trig, abort, mon_ready,
        output data_mon, mon_valid, mon_last, busy, done, trig_early
    );

endinterface

// File: rtl/mem_capture_mon_bank.sv
// mem_cap_bank: single-port synchronous RAM, DEPTH x WIDTH.
//   clk  : clock
//   en   : port enable (read when we=0, write when we=1)
//   we   : write enable
//   addr : row address
//   din  : write data
//   dout : read data, valid one cycle after a read; held until the next read
module mem_cap_bank #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 128,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             en,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we)
                mem[addr] <= din;
            else
                dout <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_capture_mon.sv
// mem_capture_mon: captures a frame of FRAME_LENGTH ADC words into a banked
// circular buffer (immediate or triggered with pre-trigger history) and
// drains it bit-serially, LSB of way 0 first, with ready/valid backpressure.
//   clk_in : sole clock
//   rst    : synchronous active-high reset
//   bus    : mem_capture_mon_if.slave (capture, monitor and status signals)
// NUM_BANKS and BANK_DEPTH must be powers of two, NUM_BANKS >= 2.
module mem_capture_mon
    import mem_cap_pkg::*;
#(
    parameter int WAY_WIDTH    = 16,
    parameter int ADC_WIDTH    = 8,
    parameter int MEM_WIDTH    = WAY_WIDTH * ADC_WIDTH,
    parameter int NUM_BANKS    = 4,
    parameter int BANK_DEPTH   = 64,
    parameter int FRAME_LENGTH = 32
) (
    input  logic             clk_in,
    input  logic             rst,
    mem_capture_mon_if.slave bus
);

    localparam int DEPTH = NUM_BANKS * BANK_DEPTH;
    localparam int AW    = $clog2(DEPTH);
    localparam int BW    = $clog2(NUM_BANKS);
    localparam int RW    = $clog2(BANK_DEPTH);
    localparam int PW    = $clog2(FRAME_LENGTH);
    localparam int CW    = $clog2(FRAME_LENGTH) + 1;
    localparam int IW    = $clog2(MEM_WIDTH);

    mem_cap_state_e state_q, state_d;

    logic [AW-1:0] wr_ptr_q, rd_ptr_q, start_q;
    logic [PW-1:0] pre_len_q;
    logic [CW-1:0] fill_cnt_q, post_cnt_q, post_tgt_q, word_cnt_q;
    logic [IW-1:0] bit_idx_q;
    logic [BW-1:0] sel_q;
    logic          trig_early_q, done_q;

    logic          wr_en, rd_en, hs, bit_end, frame_end;
    logic [AW-1:0] rd_addr, acc_addr, wr_next, rd_next, trig_start;
    logic [CW-1:0] trig_tgt;
    logic [PW-1:0] pre_clamped;
    logic [BW-1:0] acc_bank;
    logic [RW-1:0] acc_row;

    logic [MEM_WIDTH-1:0]                wr_data;
    logic [MEM_WIDTH-1:0]                rd_word;
    logic [NUM_BANKS-1:0][MEM_WIDTH-1:0] bank_dout;

    assign hs          = (state_q == ST_READ) && bus.mon_ready;
    assign bit_end     = (bit_idx_q == IW'(MEM_WIDTH - 1));
    assign frame_end   = (word_cnt_q == CW'(FRAME_LENGTH - 1));
    assign trig_tgt    = CW'(FRAME_LENGTH) - CW'(pre_len_q);
    assign pre_clamped = PW'(clamp_max(32'(bus.pre_len), FRAME_LENGTH - 1));
    assign wr_next     = AW'(addr_wrap(32'(wr_ptr_q), 1, 1'b0, DEPTH));
    assign rd_next     = AW'(addr_wrap(32'(rd_ptr_q), 1, 1'b0, DEPTH));
    // Pre-trigger start uses the pointer before the trigger cycle's write.
    assign trig_start  = AW'(addr_wrap(32'(wr_ptr_q), 32'(pre_len_q), 1'b1, DEPTH));

    // ---------------------------------------------------------------
    // Controller
    // ---------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (rst)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        rd_addr = rd_ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.arm)
                    state_d = bus.mode ? ST_FILL : ST_POST;
            end
            ST_FILL: begin
                wr_en = bus.data_valid;
                if (fill_cnt_q == CW'(pre_len_q))
                    state_d = ST_ARMED;
            end
            ST_ARMED: begin
                wr_en = bus.data_valid;
                // The trigger word itself may already complete the frame.
                if (bus.trig)
                    state_d = (bus.data_valid && trig_tgt == CW'(1)) ? ST_LOAD : ST_POST;
            end
            ST_POST: begin
                wr_en = bus.data_valid;
                if (bus.data_valid && (post_cnt_q + CW'(1) == post_tgt_q))
                    state_d = ST_LOAD;
            end
            ST_LOAD: begin
                rd_en   = 1'b1;
                rd_addr = start_q;
                state_d = ST_READ;
            end
            ST_READ: begin
                if (hs && bit_end) begin
                    if (frame_end) begin
                        state_d = ST_IDLE;
                    end else begin
                        // Fetch on the last bit's handshake so the next word's
                        // bit 0 is on the RAM output the following cycle.
                        rd_en   = 1'b1;
                        rd_addr = rd_next;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (bus.abort)
            state_d = ST_IDLE;
    end

    // ---------------------------------------------------------------
    // Datapath registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            start_q      <= '0;
            pre_len_q    <= '0;
            fill_cnt_q   <= '0;
            post_cnt_q   <= '0;
            post_tgt_q   <= '0;
            word_cnt_q   <= '0;
            bit_idx_q    <= '0;
            sel_q        <= '0;
            trig_early_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (wr_en)
                wr_ptr_q <= wr_next;
            if (rd_en)
                sel_q <= acc_bank;
            case (state_q)
                ST_IDLE: begin
                    if (bus.arm && !bus.abort) begin
                        pre_len_q    <= pre_clamped;
                        trig_early_q <= 1'b0;
                        fill_cnt_q   <= '0;
                        start_q      <= wr_ptr_q;
                        post_cnt_q   <= '0;
                        post_tgt_q   <= CW'(FRAME_LENGTH);
                    end
                end
                ST_FILL: begin
                    if (bus.data_valid)
                        fill_cnt_q <= fill_cnt_q + CW'(1);
                    if (bus.trig)
                        trig_early_q <= 1'b1;
                end
                ST_ARMED: begin
                    if (bus.trig) begin
                        start_q    <= trig_start;
                        post_tgt_q <= trig_tgt;
                        post_cnt_q <= bus.data_valid ? CW'(1) : CW'(0);
                    end
                end
                ST_POST: begin
                    if (bus.data_valid)
                        post_cnt_q <= post_cnt_q + CW'(1);
                end
                ST_LOAD: begin
                    rd_ptr_q   <= start_q;
                    bit_idx_q  <= '0;
                    word_cnt_q <= '0;
                end
                ST_READ: begin
                    if (hs) begin
                        if (bit_end) begin
                            bit_idx_q  <= '0;
                            word_cnt_q <= word_cnt_q + CW'(1);
                            rd_ptr_q   <= rd_next;
                            if (frame_end && !bus.abort)
                                done_q <= 1'b1;
                        end else begin
                            bit_idx_q <= bit_idx_q + IW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------------------------------------------------------
    // Banked buffer: bank = address MSBs, row = LSBs. Writes and reads
    // never coincide (disjoint states), so one shared access address.
    // ---------------------------------------------------------------
    assign wr_data  = bus.data_in;
    assign acc_addr = wr_en ? wr_ptr_q : rd_addr;
    assign acc_bank = acc_addr[AW-1 -: BW];
    assign acc_row  = acc_addr[RW-1:0];

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic bank_en;
        assign bank_en = (acc_bank == BW'(b)) && (wr_en || rd_en);
        mem_cap_bank #(
            .DEPTH (BANK_DEPTH),
            .WIDTH (MEM_WIDTH)
        ) u_bank (
            .clk  (clk_in),
            .en   (bank_en),
            .we   (wr_en),
            .addr (acc_row),
            .din  (wr_data),
            .dout (bank_dout[b])
        );
    end

    // sel_q is registered with the read, so it lines up with the RAM output.
    assign rd_word = bank_dout[sel_q];

    assign bus.mon_valid  = (state_q == ST_READ);
    assign bus.data_mon   = (state_q == ST_READ) && rd_word[bit_idx_q];
    assign bus.mon_last   = (state_q == ST_READ) && bit_end && frame_end;
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.done       = done_q;
    assign bus.trig_early = trig_early_q;

endmodule

// File: tb/tb_mem_capture_mon.sv
module tb_mem_capture_mon;
    import mem_cap_pkg::*;

    localparam int WAY   = 16;
    localparam int ADC   = 8;
    localparam int MW    = WAY * ADC;
    localparam int NB    = 4;
    localparam int BD    = 64;
    localparam int DEPTH = NB * BD;
    localparam int FL    = 32;
    localparam int PW    = $clog2(FL);

    logic clk_in = 1'b0;
    logic rst;
    always #5 clk_in = ~clk_in;

    mem_capture_mon_if #(.WAY_WIDTH(WAY), .ADC_WIDTH(ADC), .PRE_W(PW)) bus ();

    mem_capture_mon #(
        .WAY_WIDTH    (WAY),
        .ADC_WIDTH    (ADC),
        .NUM_BANKS    (NB),
        .BANK_DEPTH   (BD),
        .FRAME_LENGTH (FL)
    ) dut (
        .clk_in (clk_in),
        .rst    (rst),
        .bus    (bus)
    );

    int total = 0;
    int bad   = 0;

    // Every word the DUT has stored since reset, in write order.
    adc_word_t hist[$];
    int        exp_base;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    function automatic adc_word_t word_of(input int k);
        adc_word_t w;
        for (int j = 0; j < WAY; j++) w[j] = 8'(k * 16 + j);
        return w;
    endfunction

    function automatic adc_word_t rand_word();
        adc_word_t w;
        for (int j = 0; j < WAY; j++) w[j] = 8'($urandom);
        return w;
    endfunction

    task automatic arm_dut(input logic m, input int pre);
        bus.arm     = 1'b1;
        bus.mode    = m;
        bus.pre_len = PW'(pre);
        tick();
        bus.arm = 1'b0;
    endtask

    task automatic send_word(input adc_word_t w, input bit with_trig, input bit gaps);
        if (gaps) begin
            bus.data_valid = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
        end
        bus.data_in    = w;
        bus.data_valid = 1'b1;
        bus.trig       = with_trig;
        tick();
        hist.push_back(w);
        bus.data_valid = 1'b0;
        bus.trig       = 1'b0;
    endtask

    // Drain the serial stream. stop_at >= 0 returns just before that bit is
    // accepted, leaving the DUT mid-frame.
    task automatic read_frame(input string tag, input bit stall, input int stop_at);
        logic [MW-1:0] got [FL];
        int   nbits = 0, cyc = 0, stab_err = 0, last_err = 0, bubbles = 0;
        bit   started = 0, prev_stall = 0, rdy;
        logic pv = 0, pd = 0, pl = 0;
        while (nbits < FL * MW && nbits != stop_at && cyc < 20000) begin
            rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.mon_ready = rdy;
            if (prev_stall && ({bus.mon_valid, bus.data_mon, bus.mon_last} !== {pv, pd, pl}))
                stab_err++;
            if (started && !bus.mon_valid)
                bubbles++;
            if (bus.mon_valid) begin
                started = 1;
                if (rdy) begin
                    got[nbits / MW][nbits % MW] = bus.data_mon;
                    if (bus.mon_last !== (nbits == FL * MW - 1)) last_err++;
                    nbits++;
                end
            end
            prev_stall = bus.mon_valid && !rdy;
            pv = bus.mon_valid;
            pd = bus.data_mon;
            pl = bus.mon_last;
            tick();
            cyc++;
        end
        if (stop_at >= 0) begin
            chk($sformatf("%s.reach_bit", tag), 128'(nbits), 128'(stop_at));
            return;
        end
        chk($sformatf("%s.bits", tag), 128'(nbits), 128'(FL * MW));
        chk($sformatf("%s.stable", tag), 128'(stab_err), 128'(0));
        chk($sformatf("%s.last", tag), 128'(last_err), 128'(0));
        chk($sformatf("%s.bubble", tag), 128'(bubbles), 128'(0));
        for (int k = 0; k < FL; k++)
            chk($sformatf("%s.w%0d", tag, k), 128'(got[k]), 128'(hist[exp_base + k]));
        chk($sformatf("%s.done", tag), 128'(bus.done), 128'(1));
        chk($sformatf("%s.valid_off", tag), 128'(bus.mon_valid), 128'(0));
        chk($sformatf("%s.idle", tag), 128'(bus.busy), 128'(0));
        bus.mon_ready = 1'b0;
        tick();
        chk($sformatf("%s.done_pulse", tag), 128'(bus.done), 128'(0));
    endtask

    initial begin
        int t;
        int n;
        rst            = 1'b1;
        bus.data_in    = '0;
        bus.data_valid = 1'b0;
        bus.arm        = 1'b0;
        bus.mode       = 1'b0;
        bus.pre_len    = '0;
        bus.trig       = 1'b0;
        bus.abort      = 1'b0;
        bus.mon_ready  = 1'b0;
        tick();
        tick();
        chk("rst.mon_valid", 128'(bus.mon_valid), 128'(0));
        chk("rst.data_mon", 128'(bus.data_mon), 128'(0));
        chk("rst.mon_last", 128'(bus.mon_last), 128'(0));
        chk("rst.busy", 128'(bus.busy), 128'(0));
        chk("rst.done", 128'(bus.done), 128'(0));
        chk("rst.trig_early", 128'(bus.trig_early), 128'(0));
        rst = 1'b0;
        tick();

        // arm together with abort is dropped
        bus.arm   = 1'b1;
        bus.abort = 1'b1;
        tick();
        bus.arm   = 1'b0;
        bus.abort = 1'b0;
        chk("arm_abort.busy", 128'(bus.busy), 128'(0));

        // immediate mode, words 0..31, no backpressure
        arm_dut(1'b0, 0);
        chk("imm.busy", 128'(bus.busy), 128'(1));
        exp_base = hist.size();
        for (int k = 0; k < FL; k++) send_word(word_of(k), 1'b0, 1'b0);
        read_frame("imm", 1'b0, -1);

        // triggered, pre_len=8, trig on word 20 -> words 12..43
        arm_dut(1'b1, 8);
        exp_base = hist.size() + 12;
        for (int k = 0; k < 20; k++) send_word(word_of(k), 1'b0, 1'b0);
        send_word(word_of(20), 1'b1, 1'b0);
        for (int k = 21; k < 44; k++) send_word(word_of(k), 1'b0, 1'b0);
        read_frame("trg8", 1'b0, -1);

        // early trigger during FILL is flagged and ignored
        arm_dut(1'b1, 5);
        send_word(rand_word(), 1'b0, 1'b0);
        send_word(rand_word(), 1'b0, 1'b0);
        send_word(rand_word(), 1'b1, 1'b0);
        chk("early.trig_early", 128'(bus.trig_early), 128'(1));
        chk("early.busy", 128'(bus.busy), 128'(1));
        for (int k = 0; k < 10; k++) send_word(rand_word(), 1'b0, 1'b1);
        t = hist.size();
        exp_base = t - 5;
        send_word(rand_word(), 1'b1, 1'b0);
        for (int k = 0; k < FL - 5 - 1; k++) send_word(rand_word(), 1'b0, 1'b1);
        read_frame("early", 1'b0, -1);
        chk("early.sticky", 128'(bus.trig_early), 128'(1));

        // pre_len=0, random data and gaps, random 50% backpressure
        arm_dut(1'b1, 0);
        chk("bp.trig_early_clr", 128'(bus.trig_early), 128'(0));
        for (int k = 0; k < 3; k++) send_word(rand_word(), 1'b0, 1'b1);
        exp_base = hist.size();
        send_word(rand_word(), 1'b1, 1'b1);
        for (int k = 0; k < FL - 1; k++) send_word(rand_word(), 1'b0, 1'b1);
        read_frame("bp", 1'b1, -1);

        // advance the write pointer to 250 inside an aborted capture
        arm_dut(1'b1, 0);
        n = (250 - (hist.size() % DEPTH) + DEPTH) % DEPTH;
        for (int k = 0; k < n; k++) send_word(rand_word(), 1'b0, 1'b0);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("pad.abort_idle", 128'(bus.busy), 128'(0));

        // immediate capture spanning bank 3 -> bank 0 and the buffer end
        arm_dut(1'b0, 0);
        exp_base = hist.size();
        for (int k = 0; k < FL; k++) send_word(rand_word(), 1'b0, 1'b1);
        read_frame("wrap", 1'b0, -1);

        // abort at bit 1000 of the readout, then a fresh capture
        arm_dut(1'b0, 0);
        for (int k = 0; k < FL; k++) send_word(rand_word(), 1'b0, 1'b0);
        read_frame("abt", 1'b0, 1000);
        bus.abort     = 1'b1;
        bus.mon_ready = 1'b0;
        tick();
        bus.abort = 1'b0;
        chk("abt.mon_valid", 128'(bus.mon_valid), 128'(0));
        chk("abt.mon_last", 128'(bus.mon_last), 128'(0));
        chk("abt.busy", 128'(bus.busy), 128'(0));
        chk("abt.done", 128'(bus.done), 128'(0));
        tick();
        chk("abt.no_done", 128'(bus.done), 128'(0));
        arm_dut(1'b0, 0);
        exp_base = hist.size();
        for (int k = 0; k < FL; k++) send_word(rand_word(), 1'b0, 1'b1);
        read_frame("rearm", 1'b0, -1);

        // reset in the middle of a capture
        arm_dut(1'b0, 0);
        for (int k = 0; k < 5; k++) send_word(rand_word(), 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst.busy", 128'(bus.busy), 128'(0));
        chk("midrst.mon_valid", 128'(bus.mon_valid), 128'(0));
        chk("midrst.done", 128'(bus.done), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
